// File: rtl/keypad_pkg.sv
// keypad_pkg: command codes, FSM state encoding and key classification for keypad_entry.
package keypad_pkg;
  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_ENT  = 4'hE;

  typedef enum logic [1:0] {ARM, ENTRY, SUBMIT} state_t;

  function automatic logic is_digit(input logic [3:0] c);
    return c < 4'd10;
  endfunction
endpackage

// File: rtl/key_event_detect.sv
// key_event_detect: synchronises the held decoder code and debounces changes into one-cycle key events.
module key_event_detect #(
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_key_code,
  input  logic       i_arm,
  output logic       o_event,
  output logic [3:0] o_value,
  output logic       o_armed
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [3:0]    r_sync1, r_code_s, r_cand, r_last;
  logic [CW-1:0] r_cnt;
  logic          w_live, w_stable;

  // While arming, the power-up code is absorbed into last even if it equals the reset value.
  assign w_live   = i_arm || (r_cand != r_last);
  assign w_stable = (r_code_s == r_cand) && (r_cnt == CW'(STABLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_code_s <= '0;
      r_cand   <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      o_event  <= 1'b0;
      o_value  <= '0;
      o_armed  <= 1'b0;
    end else begin
      r_sync1  <= i_key_code;
      r_code_s <= r_sync1;
      o_event  <= 1'b0;
      o_armed  <= 1'b0;
      if (r_code_s != r_cand) begin
        r_cand <= r_code_s;
        r_cnt  <= '0;
      end else if (w_stable && w_live) begin
        r_last  <= r_cand;
        r_cnt   <= '0;
        o_event <= !i_arm;
        o_armed <= i_arm;
        if (!i_arm) o_value <= r_cand;
      end else begin
        r_cnt <= w_live ? r_cnt + CW'(1) : '0;
      end
    end
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: turns debounced keypad events into a NUM_DIGITS-digit hand and offers it over valid/ready.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [3:0]                      key_code,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [4*NUM_DIGITS-1:0]         out_digits,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            key_event,
  output logic [3:0]                      key_value
);
  localparam int CW = $clog2(NUM_DIGITS + 1);

  state_t                  r_state, w_state_nxt;
  logic [4*NUM_DIGITS-1:0] r_slots, w_slots_nxt;
  logic [CW-1:0]           r_count, w_count_nxt;
  logic                    w_event, w_armed;
  logic [3:0]              w_value;

  key_event_detect #(.STABLE_CYCLES(STABLE_CYCLES)) u_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_key_code(key_code),
    .i_arm     (r_state == ARM),
    .o_event   (w_event),
    .o_value   (w_value),
    .o_armed   (w_armed)
  );

  assign key_event   = w_event;
  assign key_value   = w_value;
  assign out_valid   = r_state == SUBMIT;
  assign out_digits  = r_slots;
  assign digit_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARM;
      r_slots <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slots <= w_slots_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_slots_nxt = r_slots;
    w_count_nxt = r_count;
    case (r_state)
      ARM: w_state_nxt = w_armed ? ENTRY : ARM;
      ENTRY: if (w_event) begin
        if (is_digit(w_value)) begin
          if (r_count < CW'(NUM_DIGITS)) begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (CW'(i) == r_count) w_slots_nxt[4*i+:4] = w_value;
            w_count_nxt = r_count + CW'(1);
          end
        end else if (w_value == KEY_BKSP) begin
          if (r_count != '0) begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (CW'(i + 1) == r_count) w_slots_nxt[4*i+:4] = '0;
            w_count_nxt = r_count - CW'(1);
          end
        end else if (w_value == KEY_CLR) begin
          w_slots_nxt = '0;
          w_count_nxt = '0;
        end else if (w_value == KEY_ENT && r_count == CW'(NUM_DIGITS)) begin
          w_state_nxt = SUBMIT;
        end
      end
      // Events arriving here are deliberately not applied to the buffer.
      SUBMIT: if (out_ready) begin
        w_slots_nxt = '0;
        w_count_nxt = '0;
        w_state_nxt = ENTRY;
      end
      default: w_state_nxt = ARM;
    endcase
  end
endmodule
